// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: opcodes, the
// exec/idle encoding of `state` and the sequencer FSM encodings.
package pipeline_ctrl_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam logic ST_EXEC = 1'b1;
    localparam logic ST_IDLE = 1'b0;

    typedef enum logic [1:0] {
        PCTRL_IDLE      = 2'd0,
        PCTRL_RUN       = 2'd1,
        PCTRL_STEP_WAIT = 2'd2,
        PCTRL_HALTED    = 2'd3
    } pctrl_e;

    function automatic logic [4:0] opcode(input logic [15:0] ir);
        return ir[15:11];
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Control bus between the sequencer and the stage registers.
// master: sequencer (reads IRs/jump, drives enables); slave: datapath.
interface pipeline_ctrl_if;

    logic [15:0] id_ir;
    logic [15:0] ex_ir;
    logic [15:0] wb_ir;
    logic        jump;
    logic        pc_we;
    logic        id_ex_bubble;
    logic        if_id_flush;

    modport master (
        input  id_ir, ex_ir, wb_ir, jump,
        output pc_we, id_ex_bubble, if_id_flush
    );

    modport slave (
        output id_ir, ex_ir, wb_ir, jump,
        input  pc_we, id_ex_bubble, if_id_flush
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: id_ir, ex_ir in; load_use out when
// the LOAD in EX writes a register that the ID instruction reads.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [15:0] id_ir,
    input  logic [15:0] ex_ir,
    output logic        load_use
);

    logic [4:0] id_op;
    logic [2:0] dst;
    logic       rd1;
    logic       rd2;
    logic       rd3;
    logic       hit;
    logic       unused_bits;

    assign id_op = opcode(id_ir);
    assign dst   = ex_ir[10:8];

    assign rd1 = id_op inside {OP_BZ, OP_BNZ, OP_BN, OP_BNN,
                               OP_BC, OP_BNC, OP_JMPR, OP_ADDI,
                               OP_SUBI, OP_LDIH, OP_STORE};

    assign rd2 = id_op inside {OP_LOAD, OP_STORE, OP_ADD, OP_ADDC,
                               OP_SUB, OP_SUBC, OP_CMP, OP_AND,
                               OP_OR, OP_XOR, OP_SLL, OP_SRL,
                               OP_SLA, OP_SRA};

    assign rd3 = id_op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
                               OP_CMP, OP_AND, OP_OR, OP_XOR};

    assign hit = (rd1 && id_ir[10:8] == dst)
              || (rd2 && id_ir[6:4] == dst)
              || (rd3 && id_ir[2:0] == dst);

    // NOP and JUMP read no register; kept explicit for readers.
    assign load_use = opcode(ex_ir) == OP_LOAD
                   && id_op != OP_NOP
                   && id_op != OP_JUMP
                   && hit;

    assign unused_bits = ^{ex_ir[7:0], id_ir[7], id_ir[3]};

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: run/step/halt FSM, load-use stall, jump flush,
// perf counters. Ports: clock, reset, start, step_mode, step, bus
// (IRs/jump in, pc_we/bubble/flush out), state, halted, *_cnt.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int          CNT_W  = 16,
    parameter logic [15:0] NOP_IR = 16'h0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    pipeline_ctrl_if.master  bus,
    output logic             state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    pctrl_e fsm_q;
    pctrl_e fsm_d;
    logic   step_q;
    logic   step_go;
    logic   wb_halt;
    logic   go;
    logic   load_use;
    logic   stall;

    hazard_detect u_hazard (
        .id_ir    (bus.id_ir),
        .ex_ir    (bus.ex_ir),
        .load_use (load_use)
    );

    assign wb_halt = opcode(bus.wb_ir) == OP_HALT;

    // One exec cycle per rising edge of step, even if step is held.
    assign step_go = step && !step_q && step_mode;

    assign go = start && !wb_halt
             && (fsm_q == PCTRL_IDLE || fsm_q == PCTRL_HALTED);

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm_q  <= PCTRL_IDLE;
            step_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            step_q <= step;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            PCTRL_IDLE, PCTRL_HALTED: begin
                if (start) begin
                    if (wb_halt)        fsm_d = PCTRL_HALTED;
                    else if (step_mode) fsm_d = PCTRL_STEP_WAIT;
                    else                fsm_d = PCTRL_RUN;
                end
            end
            PCTRL_RUN: begin
                if (wb_halt)        fsm_d = PCTRL_HALTED;
                else if (step_mode) fsm_d = PCTRL_STEP_WAIT;
            end
            PCTRL_STEP_WAIT: begin
                if (wb_halt)         fsm_d = PCTRL_HALTED;
                else if (!step_mode) fsm_d = PCTRL_RUN;
            end
            default: fsm_d = PCTRL_IDLE;
        endcase
    end

    always_comb begin
        state  = ST_IDLE;
        halted = 1'b0;
        unique case (fsm_q)
            PCTRL_RUN:       state = ST_EXEC;
            PCTRL_STEP_WAIT: state = step_go && !wb_halt;
            PCTRL_HALTED:    halted = 1'b1;
            default:         state = ST_IDLE;
        endcase
    end

    // A jump redirects the front end, which makes the stall moot.
    assign stall = state && load_use && !bus.jump;

    assign bus.pc_we        = state && !stall;
    assign bus.id_ex_bubble = state && (stall || bus.jump);
    assign bus.if_id_flush  = state && bus.jump;

    always_ff @(posedge clock) begin
        if (reset || go) begin
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
            retire_cnt <= '0;
        end else if (state == ST_EXEC) begin
            if (cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.wb_ir != NOP_IR && retire_cnt != '1)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, load-use stalls, jump
// override, single-step, HALT retirement and counter saturation.
module tb_pipeline_ctrl;

    import pipeline_ctrl_pkg::*;

    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          step_mode;
    logic          step;
    logic          state;
    logic          halted;
    logic [TW-1:0] cycle_cnt;
    logic [TW-1:0] stall_cnt;
    logic [TW-1:0] retire_cnt;

    pipeline_ctrl_if bus ();

    pipeline_ctrl #(
        .CNT_W  (TW),
        .NOP_IR (16'h0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .step_mode  (step_mode),
        .step       (step),
        .bus        (bus),
        .state      (state),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [4:0] op,
                                        input logic [2:0] a,
                                        input logic [2:0] b,
                                        input logic [2:0] c);
        return {op, a, 1'b0, b, 1'b0, c};
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic ctl(input string tag, input logic pw,
                       input logic bub, input logic fl);
        #1;
        chk({tag, ".pc_we"}, 32'(bus.pc_we), 32'(pw));
        chk({tag, ".bubble"}, 32'(bus.id_ex_bubble), 32'(bub));
        chk({tag, ".flush"}, 32'(bus.if_id_flush), 32'(fl));
    endtask

    typedef struct {
        logic [15:0] ex;
        logic [15:0] id;
        logic        j;
        logic        pw;
        logic        bub;
        logic        fl;
    } vec_t;

    vec_t v[11];
    int   hi;

    initial begin
        v[0]  = '{ins(OP_LOAD,1,2,0), ins(OP_ADD,3,1,4),   1'b0, 1'b0, 1'b1, 1'b0};
        v[1]  = '{16'h0000,           ins(OP_ADD,3,1,4),   1'b0, 1'b1, 1'b0, 1'b0};
        v[2]  = '{ins(OP_LOAD,1,2,0), ins(OP_ADD,3,2,4),   1'b0, 1'b1, 1'b0, 1'b0};
        v[3]  = '{ins(OP_LOAD,1,2,0), ins(OP_STORE,1,2,0), 1'b0, 1'b0, 1'b1, 1'b0};
        v[4]  = '{ins(OP_LOAD,1,2,0), ins(OP_SUB,5,6,1),   1'b0, 1'b0, 1'b1, 1'b0};
        v[5]  = '{ins(OP_LOAD,1,2,0), ins(OP_JUMP,1,1,1),  1'b0, 1'b1, 1'b0, 1'b0};
        v[6]  = '{ins(OP_LOAD,0,2,0), 16'h0000,            1'b0, 1'b1, 1'b0, 1'b0};
        v[7]  = '{ins(OP_LOAD,1,2,0), ins(OP_ADD,3,1,4),   1'b1, 1'b1, 1'b1, 1'b1};
        v[8]  = '{ins(OP_LOAD,2,0,0), ins(OP_SLL,1,2,3),   1'b0, 1'b0, 1'b1, 1'b0};
        v[9]  = '{ins(OP_LOAD,3,0,0), ins(OP_SLL,1,2,3),   1'b0, 1'b1, 1'b0, 1'b0};
        v[10] = '{ins(OP_ADD,1,2,3),  ins(OP_ADD,3,1,4),   1'b0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        step_mode = 1'b0;
        step = 1'b0;
        bus.id_ir = 16'h0000;
        bus.ex_ir = 16'h0000;
        bus.wb_ir = 16'h0000;
        bus.jump = 1'b0;
        tick;
        tick;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.halted", 32'(halted), 32'd0);
        chk("rst.cycle", 32'(cycle_cnt), 32'd0);
        chk("rst.stall", 32'(stall_cnt), 32'd0);
        chk("rst.retire", 32'(retire_cnt), 32'd0);

        // Idle gates every control output, hazard or not.
        reset = 1'b0;
        bus.ex_ir = ins(OP_LOAD, 1, 2, 0);
        bus.id_ir = ins(OP_ADD, 3, 1, 4);
        bus.jump = 1'b1;
        ctl("idle", 1'b0, 1'b0, 1'b0);
        bus.ex_ir = 16'h0000;
        bus.id_ir = 16'h0000;
        bus.jump = 1'b0;

        // Reset mid-run with non-zero counters.
        start = 1'b1;
        tick;
        start = 1'b0;
        bus.wb_ir = ins(OP_ADD, 1, 2, 3);
        tick;
        tick;
        tick;
        chk("run.state", 32'(state), 32'd1);
        chk("run.cycle", 32'(cycle_cnt), 32'd3);
        chk("run.retire", 32'(retire_cnt), 32'd3);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        bus.wb_ir = 16'h0000;
        chk("mrst.state", 32'(state), 32'd0);
        chk("mrst.cycle", 32'(cycle_cnt), 32'd0);
        chk("mrst.retire", 32'(retire_cnt), 32'd0);
        chk("mrst.pc_we", 32'(bus.pc_we), 32'd0);

        // Hazard vectors, one cycle each, in RUN.
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus.ex_ir = v[i].ex;
            bus.id_ir = v[i].id;
            bus.jump = v[i].j;
            ctl($sformatf("hz%0d", i), v[i].pw, v[i].bub, v[i].fl);
            if (i == 0) begin
                tick;
                chk("hz0.stall_cnt", 32'(stall_cnt), 32'd1);
            end else begin
                tick;
            end
        end
        bus.ex_ir = 16'h0000;
        bus.id_ir = 16'h0000;
        bus.jump = 1'b0;
        chk("hz.stall_cnt", 32'(stall_cnt), 32'd4);

        // Single-step: three spaced pulses, three exec cycles.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        step_mode = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        #1;
        chk("sw.state", 32'(state), 32'd0);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            step = (i % 4 == 0) && (i < 12);
            #2;
            hi += int'(state);
            tick;
        end
        step = 1'b0;
        chk("step.hi", 32'(hi), 32'd3);
        chk("step.cycle", 32'(cycle_cnt), 32'd3);

        // Back to RUN, then HALT in WB with a start pulse.
        step_mode = 1'b0;
        tick;
        chk("resume.state", 32'(state), 32'd1);
        bus.wb_ir = ins(OP_HALT, 0, 0, 0);
        start = 1'b1;
        #1;
        chk("halt.exec", 32'(state), 32'd1);
        tick;
        start = 1'b0;
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.state", 32'(state), 32'd0);
        chk("halt.pc_we", 32'(bus.pc_we), 32'd0);
        chk("halt.cycle", 32'(cycle_cnt), 32'd4);
        chk("halt.retire", 32'(retire_cnt), 32'd1);
        tick;
        tick;
        chk("halt.hold", 32'(cycle_cnt), 32'd4);

        // Restart from HALTED clears halted and counters.
        bus.wb_ir = 16'h0000;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("re.halted", 32'(halted), 32'd0);
        chk("re.state", 32'(state), 32'd1);
        chk("re.cycle", 32'(cycle_cnt), 32'd0);
        chk("re.retire", 32'(retire_cnt), 32'd0);

        // Counters saturate at all-ones.
        bus.wb_ir = ins(OP_ADD, 1, 2, 3);
        bus.ex_ir = ins(OP_LOAD, 1, 2, 0);
        bus.id_ir = ins(OP_ADD, 3, 1, 4);
        repeat (20) tick;
        chk("sat.cycle", 32'(cycle_cnt), 32'd15);
        chk("sat.stall", 32'(stall_cnt), 32'd15);
        chk("sat.retire", 32'(retire_cnt), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central sequencer for the 5-stage 16-bit pipeline. Drives the global `state` (idle/exec) consumed by every stage register, and detects load-use hazards that forwarding cannot cover. Converts those hazards into a one-cycle PC/IF-ID hold plus an EX bubble, and gives redirect flushes priority over stalls. Also handles start, single-step, HALT retirement, and performance counters; sits beside the stage modules at top level.

Parameters:
CNT_W, 16, width of the cycle, stall and retire counters (saturating).
NOP_IR, 16'h0000, instruction word injected as a bubble.

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high; clears all state
start  in  1  pulse; leaves IDLE/HALTED and begins execution
step_mode  in  1  1 = advance only on step pulses
step  in  1  single-cycle advance request, honoured only when step_mode=1
id_ir  in  16  instruction currently in ID
ex_ir  in  16  instruction currently in EX
wb_ir  in  16  instruction currently in WB
jump  in  1  taken branch/jump resolved this cycle
state  out  1  1 = exec (stages advance), 0 = idle (all stages hold)
pc_we  out  1  PC and IF/ID register update enable
id_ex_bubble  out  1  ID loads NOP_IR into ex_ir instead of id_ir
if_id_flush  out  1  IF/ID register loads NOP_IR
halted  out  1  HALT has retired
cycle_cnt  out  CNT_W  exec cycles since start
stall_cnt  out  CNT_W  load-use stall cycles
retire_cnt  out  CNT_W  non-NOP instructions leaving WB

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, state=0, pc_we=0, id_ex_bubble=0, if_id_flush=0, halted=0, all counters=0. Applies mid-run with no drain.
- FSM states: IDLE, RUN, STEP_WAIT, HALTED.
  - IDLE --start--> RUN if step_mode=0, else STEP_WAIT.
  - RUN: state=1 every cycle. Goes to STEP_WAIT if step_mode rises. Goes to HALTED when wb_ir[15:11]==HALT.
  - STEP_WAIT: state=0. On step, drive state=1 for exactly one cycle, then return to STEP_WAIT. Goes to RUN if step_mode falls. Goes to HALTED on HALT in WB.
  - HALTED: state=0, halted=1. start clears halted and counters, then transitions as from IDLE.
- HALT in WB takes priority over start and step in the same cycle.
- Load-use detect (combinational, qualified by state=1):
  - Condition: ex_ir[15:11]==LOAD and id_ir reads ex_ir[10:8].
  - r1 field [10:8] is read by BZ, BNZ, BN, BNN, BC, BNC, JMPR, ADDI, SUBI, LDIH, STORE (store data).
  - r2 field [6:4] is read by LOAD, STORE, ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR, SLL, SRL, SLA, SRA.
  - r3 field [2:0] is read by ADD, ADDC, SUB, SUBC, CMP, AND, OR, XOR.
  - NOP and JUMP never stall.
- On stall: pc_we=0 (PC and IF/ID hold), id_ex_bubble=1. Lasts exactly one cycle; the next cycle the LOAD sits in MEM and forwarding covers the dependency.
- On jump with state=1: if_id_flush=1, id_ex_bubble=1, pc_we=1 (PC takes the target). Jump overrides a simultaneous stall: no stall, stall_cnt does not increment.
- When state=0: pc_we=0, id_ex_bubble=0, if_id_flush=0.
- Control outputs are combinational from the FSM register and the IR inputs. Counters are registered, increment only when state=1, and saturate at all-ones.
- retire_cnt increments when state=1 and wb_ir!=NOP_IR.

Decomposition:
- Opcode constants (LOAD, STORE, HALT, JUMP, branch and ALU codes) and the exec/idle encodings come from the shared define header.
- FSM state encodings go in the same header under a PCTRL_ prefix.
- One sub-module: hazard_detect, purely combinational (id_ir, ex_ir -> load_use). Reused later by a debug monitor.

Test Plan:
- reset=1 while in RUN with counters non-zero -> next cycle state=0, all counters 0, FSM IDLE.
- start; ex_ir=LOAD r1,r2,#0; id_ir=ADD r3,r1,r4 -> one cycle pc_we=0, id_ex_bubble=1, stall_cnt=1; next cycle pc_we=1.
- ex_ir=LOAD r1; id_ir=ADD r3,r2,r4 (no r1 use) -> no stall. Same pair with id_ir=STORE r1,r2,#0 -> stall via r1 field.
- Load-use condition and jump=1 in same cycle -> if_id_flush=1, id_ex_bubble=1, pc_we=1, stall_cnt unchanged.
- step_mode=1, start, three step pulses spaced 4 cycles apart -> state=1 for exactly 3 cycles; cycle_cnt=3.
- HALT reaches WB together with a start pulse -> HALTED, halted=1, state=0. Later start -> halted=0, counters 0, RUN.
